// File: rtl/decode_issue_queue.sv
// Decode/issue queue: FIFO of fetched words, combinational decode of the head,
// and a pending-write scoreboard that holds issue on register hazards.

package decoder_pkg;

   typedef enum logic [5:0] {
      OP_NOP  = 6'h00,
      OP_ADD  = 6'h01,
      OP_ADDI = 6'h02,
      OP_MADD = 6'h03,
      OP_LI   = 6'h04,
      OP_CMP  = 6'h05,
      OP_BC   = 6'h06,
      OP_ST   = 6'h07
   } op_e;

   typedef struct packed {
      logic [5:0] op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rs3;
      logic [5:0] imm;
      logic       r_rs1;
      logic       r_rs2;
      logic       r_rs3;
      logic       w_rd;
      logic       r_cr;
      logic       w_cr;
      logic       udf;
   } decoded_t;

   // Fixed field layout: op[31:26] rd[25:21] rs1[20:16] rs2[15:11] rs3[10:6] imm[5:0].
   function automatic decoded_t decode(input logic [31:0] instr);
      decoded_t d;
      d     = '0;
      d.op  = instr[31:26];
      d.rd  = instr[25:21];
      d.rs1 = instr[20:16];
      d.rs2 = instr[15:11];
      d.rs3 = instr[10:6];
      d.imm = instr[5:0];
      case (instr[31:26])
         OP_NOP:  ;
         OP_ADD:  begin d.w_rd = 1'b1; d.r_rs1 = 1'b1; d.r_rs2 = 1'b1; end
         OP_ADDI: begin d.w_rd = 1'b1; d.r_rs1 = 1'b1; end
         OP_MADD: begin d.w_rd = 1'b1; d.r_rs1 = 1'b1; d.r_rs2 = 1'b1; d.r_rs3 = 1'b1; end
         OP_LI:   d.w_rd = 1'b1;
         OP_CMP:  begin d.w_cr = 1'b1; d.r_rs1 = 1'b1; d.r_rs2 = 1'b1; end
         OP_BC:   d.r_cr = 1'b1;
         OP_ST:   begin d.r_rs1 = 1'b1; d.r_rs2 = 1'b1; end
         default: d.udf = 1'b1;
      endcase
      return d;
   endfunction

endpackage

module decode_issue_queue
   import decoder_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 2,
   parameter int NREGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output decoded_t    out_dec,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        wb_cr,
   output logic        stall_hazard,
   output logic [31:0] stall_cycles
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [31:0]      instr_mem [DEPTH];
   logic [31:0]      pc_mem    [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;
   logic [CNT_W-1:0] pend [NREGS];
   logic [CNT_W-1:0] pend_cr;
   logic             hazard;
   logic             push;
   logic             pop;
   logic             cr_inc;
   logic             cr_dec;
   logic [NREGS-1:0] sb_inc;
   logic [NREGS-1:0] sb_dec;

   assign out_instr = instr_mem[head];
   assign out_pc    = pc_mem[head];
   assign out_dec   = decode(out_instr);

   // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      hazard = 1'b0;
      if (out_dec.r_rs1 && out_dec.rs1 != '0 && pend[out_dec.rs1] != '0) hazard = 1'b1;
      if (out_dec.r_rs2 && out_dec.rs2 != '0 && pend[out_dec.rs2] != '0) hazard = 1'b1;
      if (out_dec.r_rs3 && out_dec.rs3 != '0 && pend[out_dec.rs3] != '0) hazard = 1'b1;
      if (out_dec.w_rd && pend[out_dec.rd] == CNT_MAX)                    hazard = 1'b1;
      if (out_dec.r_cr && pend_cr != '0)                                  hazard = 1'b1;
      if (out_dec.w_cr && pend_cr == CNT_MAX)                             hazard = 1'b1;
      if (out_dec.udf)                                                    hazard = 1'b0;
   end

   assign in_ready     = !rst && !flush && (count < FULL_CNT);
   assign out_valid    = !rst && !flush && (count != '0) && !hazard;
   assign stall_hazard = !rst && !flush && (count != '0) && hazard;
   assign push         = in_valid && in_ready;
   assign pop          = out_valid && out_ready;
   assign cr_inc       = pop && out_dec.w_cr;
   assign cr_dec       = wb_cr;

   always_comb begin
      sb_inc = '0;
      sb_dec = '0;
      if (pop && out_dec.w_rd) sb_inc[out_dec.rd] = 1'b1;
      if (wb_valid)            sb_dec[wb_rd]      = 1'b1;
      // r0 is hardwired zero and never tracked
      sb_inc[0] = 1'b0;
      sb_dec[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= tail;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: the entry storage has no reset; an entry is only observed once count marks it valid.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[tail] <= in_instr;
         pc_mem[tail]    <= in_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) pend[r] <= '0;
         pend_cr      <= '0;
         stall_cycles <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (sb_inc[r] && !sb_dec[r] && pend[r] != CNT_MAX)
               pend[r] <= pend[r] + 1'b1;
            else if (sb_dec[r] && !sb_inc[r] && pend[r] != '0)
               pend[r] <= pend[r] - 1'b1;
         end
         if (cr_inc && !cr_dec && pend_cr != CNT_MAX)
            pend_cr <= pend_cr + 1'b1;
         else if (cr_dec && !cr_inc && pend_cr != '0)
            pend_cr <= pend_cr - 1'b1;
         if (stall_hazard) stall_cycles <= stall_cycles + 1'b1;
      end
   end

   // A writeback must always retire a write that was previously issued
   wb_underflow: assert property (@(posedge clk) disable iff (rst)
      (wb_valid && wb_rd != '0) |-> (pend[wb_rd] != '0));
   cr_underflow: assert property (@(posedge clk) disable iff (rst)
      wb_cr |-> (pend_cr != '0));

endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: directed hazard/flush/reset scenarios then random
// traffic, checked every cycle against a queue-and-counter reference model.

module tb_decode_issue_queue;
   import decoder_pkg::*;

   localparam int DEPTH = 4;
   localparam int SAT   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   decoded_t    out_dec;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic        wb_cr = 1'b0;
   logic        stall_hazard;
   logic [31:0] stall_cycles;

   always #5 clk = ~clk;

   decode_issue_queue #(.DEPTH(DEPTH), .CNT_W(2), .NREGS(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_dec(out_dec),
      .out_instr(out_instr), .out_pc(out_pc),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_cr(wb_cr),
      .stall_hazard(stall_hazard), .stall_cycles(stall_cycles)
   );

   typedef struct { logic [31:0] instr; logic [31:0] pc; } entry_t;

   entry_t      exp_q[$];
   int          pend_m[32];
   int          pend_cr_m = 0;
   logic [31:0] stall_m = '0;
   logic [31:0] pc_next = 32'h1000;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timed_out(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rs3);
      return {op, rd, rs1, rs2, rs3, 6'h2a};
   endfunction

   // Per-opcode operand usage: {reads rs1, rs2, rs3, writes rd, reads cr, writes cr}
   function automatic decoded_t ref_decode(input logic [31:0] w);
      decoded_t   d;
      logic [5:0] use_f;
      d     = '0;
      d.op  = w[31:26];
      d.rd  = w[25:21];
      d.rs1 = w[20:16];
      d.rs2 = w[15:11];
      d.rs3 = w[10:6];
      d.imm = w[5:0];
      case (w[31:26])
         6'h00:   use_f = 6'b000000;
         6'h01:   use_f = 6'b110100;
         6'h02:   use_f = 6'b100100;
         6'h03:   use_f = 6'b111100;
         6'h04:   use_f = 6'b000100;
         6'h05:   use_f = 6'b110001;
         6'h06:   use_f = 6'b000010;
         6'h07:   use_f = 6'b110000;
         default: begin use_f = 6'b000000; d.udf = 1'b1; end
      endcase
      {d.r_rs1, d.r_rs2, d.r_rs3, d.w_rd, d.r_cr, d.w_cr} = use_f;
      return d;
   endfunction

   function automatic bit hazard_m(input decoded_t d);
      if (d.udf) return 1'b0;
      if (d.r_rs1 && d.rs1 != 0 && pend_m[d.rs1] > 0) return 1'b1;
      if (d.r_rs2 && d.rs2 != 0 && pend_m[d.rs2] > 0) return 1'b1;
      if (d.r_rs3 && d.rs3 != 0 && pend_m[d.rs3] > 0) return 1'b1;
      if (d.w_rd && d.rd != 0 && pend_m[d.rd] >= SAT) return 1'b1;
      if (d.r_cr && pend_cr_m > 0) return 1'b1;
      if (d.w_cr && pend_cr_m >= SAT) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int pick_pending();
      int c[$];
      for (int r = 1; r < 32; r++) if (pend_m[r] > 0) c.push_back(r);
      if (c.size() == 0) return 0;
      return c[$urandom_range(c.size() - 1)];
   endfunction

   function automatic bit model_busy();
      if (exp_q.size() != 0 || pend_cr_m != 0) return 1'b1;
      for (int r = 1; r < 32; r++) if (pend_m[r] != 0) return 1'b1;
      return 1'b0;
   endfunction

   // Monitor: compare at negedge, then advance the model across the coming edge
   initial begin : monitor
      decoded_t d;
      bit       hz, e_ir, e_ov, e_sh;
      for (int r = 0; r < 32; r++) pend_m[r] = 0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         d  = '0;
         hz = 1'b0;
         if (exp_q.size() != 0) begin
            d  = ref_decode(exp_q[0].instr);
            hz = hazard_m(d);
         end
         e_ir = !rst && !flush && exp_q.size() < DEPTH;
         e_ov = !rst && !flush && exp_q.size() != 0 && !hz;
         e_sh = !rst && !flush && exp_q.size() != 0 && hz;
         check("in_ready", 64'(in_ready), 64'(e_ir));
         check("out_valid", 64'(out_valid), 64'(e_ov));
         check("stall_hazard", 64'(stall_hazard), 64'(e_sh));
         check("stall_cycles", 64'(stall_cycles), 64'(stall_m));
         if (e_ov) begin
            check("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
            check("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
            check("out_dec", 64'(out_dec), 64'(d));
         end
         if (rst) begin
            exp_q.delete();
            for (int r = 0; r < 32; r++) pend_m[r] = 0;
            pend_cr_m = 0;
            stall_m   = '0;
         end else begin
            if (e_sh) stall_m++;
            if (e_ov && out_ready) begin
               if (d.w_rd && d.rd != 0) pend_m[d.rd]++;
               if (d.w_cr) pend_cr_m++;
               void'(exp_q.pop_front());
            end
            if (wb_valid && wb_rd != 0 && pend_m[wb_rd] > 0) pend_m[wb_rd]--;
            if (wb_cr && pend_cr_m > 0) pend_cr_m--;
            if (flush) exp_q.delete();
            else if (in_valid && e_ir) exp_q.push_back('{in_instr, in_pc});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [31:0] w);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_instr = w;
      in_pc    = pc_next;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         ok = in_ready;
         tick();
      end
      in_valid = 1'b0;
      pc_next += 4;
      if (!ok) timed_out("send");
   endtask

   task automatic wait_issue(input string name);
      bit ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         ok = out_valid && out_ready;
         tick();
      end
      if (!ok) timed_out(name);
   endtask

   task automatic wb(input logic [4:0] r);
      wb_valid = 1'b1;
      wb_rd    = r;
      tick();
      wb_valid = 1'b0;
   endtask

   task automatic expect_stall(input string name);
      @(negedge clk);
      check(name, 64'(stall_hazard), 64'(1));
      tick();
   endtask

   task automatic retire_all();
      int r;
      out_ready = 1'b1;
      for (int t = 0; t < 500 && model_busy(); t++) begin
         r        = pick_pending();
         wb_valid = (r != 0);
         wb_rd    = 5'(r);
         wb_cr    = (pend_cr_m > 0);
         tick();
      end
      wb_valid = 1'b0;
      wb_cr    = 1'b0;
      if (model_busy()) timed_out("retire_all");
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] op;
      op = ($urandom_range(9) == 0) ? 6'h3f : 6'($urandom_range(7));
      return {op, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
              5'($urandom_range(7)), 6'($urandom_range(63))};
   endfunction

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stimulus
      int r;
      idle(3);
      rst = 1'b0;
      tick();

      // Fill four entries without draining, then hold a fifth while full
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(mk(6'h07, 5'd0, 5'd0, 5'd0, 5'd0));
      in_valid = 1'b1;
      in_instr = mk(6'h00, 5'd0, 5'd0, 5'd0, 5'd0);
      in_pc    = pc_next;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("full_hold", 64'(in_ready), 64'(0));
         tick();
      end
      out_ready = 1'b1;
      send(mk(6'h00, 5'd0, 5'd0, 5'd0, 5'd0));
      idle(6);

      // Read-after-write stall released by writeback
      send(mk(6'h04, 5'd5, 5'd0, 5'd0, 5'd0));
      wait_issue("raw_write");
      send(mk(6'h01, 5'd6, 5'd5, 5'd0, 5'd0));
      for (int i = 0; i < 3; i++) expect_stall("raw_stall");
      wb(5'd5);
      wait_issue("raw_release");
      retire_all();

      // Issue and writeback to r7 in the same cycle keeps pend[7] at 1
      send(mk(6'h04, 5'd7, 5'd0, 5'd0, 5'd0));
      wait_issue("same_first");
      out_ready = 1'b0;
      send(mk(6'h04, 5'd7, 5'd0, 5'd0, 5'd0));
      out_ready = 1'b1;
      wb_valid  = 1'b1;
      wb_rd     = 5'd7;
      tick();
      wb_valid = 1'b0;
      send(mk(6'h02, 5'd8, 5'd7, 5'd0, 5'd0));
      for (int i = 0; i < 2; i++) expect_stall("same_stall");
      wb(5'd7);
      wait_issue("same_release");
      retire_all();

      // Saturation: three writes to r3 in flight, the fourth waits
      for (int i = 0; i < 3; i++) send(mk(6'h04, 5'd3, 5'd0, 5'd0, 5'd0));
      idle(1);
      send(mk(6'h04, 5'd3, 5'd0, 5'd0, 5'd0));
      for (int i = 0; i < 2; i++) expect_stall("sat_stall");
      wb(5'd3);
      wait_issue("sat_release");
      retire_all();

      // Condition register: branch waits for the compare to retire
      send(mk(6'h05, 5'd0, 5'd1, 5'd2, 5'd0));
      wait_issue("cr_write");
      send(mk(6'h06, 5'd0, 5'd0, 5'd0, 5'd0));
      for (int i = 0; i < 2; i++) expect_stall("cr_stall");
      wb_cr = 1'b1;
      tick();
      wb_cr = 1'b0;
      wait_issue("cr_release");

      // Flush drops queued entries and the concurrent input, keeps pending counts
      send(mk(6'h04, 5'd9, 5'd0, 5'd0, 5'd0));
      wait_issue("flush_pend");
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(mk(6'h00, 5'd0, 5'd0, 5'd0, 5'd0));
      in_valid = 1'b1;
      in_instr = mk(6'h07, 5'd0, 5'd0, 5'd0, 5'd0);
      in_pc    = pc_next;
      pc_next += 4;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_empty", 64'(out_valid), 64'(0));
      check("flush_ready", 64'(in_ready), 64'(1));
      tick();
      out_ready = 1'b1;
      send(mk(6'h02, 5'd10, 5'd9, 5'd0, 5'd0));
      for (int i = 0; i < 2; i++) expect_stall("flush_keeps_pend");
      wb(5'd9);
      wait_issue("flush_release");
      retire_all();

      // Reset mid-stream clears queue, pending counts and stall counter
      send(mk(6'h04, 5'd12, 5'd0, 5'd0, 5'd0));
      wait_issue("rst_pend");
      send(mk(6'h02, 5'd13, 5'd12, 5'd0, 5'd0));
      expect_stall("rst_pre_stall");
      out_ready = 1'b0;
      send(mk(6'h00, 5'd0, 5'd0, 5'd0, 5'd0));
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      check("rst_stall_cycles", 64'(stall_cycles), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      tick();
      out_ready = 1'b1;
      send(mk(6'h02, 5'd13, 5'd12, 5'd0, 5'd0));
      wait_issue("rst_no_stall");
      retire_all();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(99) < 60);
         in_instr  = rand_instr();
         in_pc     = pc_next;
         pc_next  += 4;
         out_ready = ($urandom_range(99) < 70);
         flush     = ($urandom_range(99) < 2);
         r         = pick_pending();
         wb_valid  = (r != 0) ? ($urandom_range(99) < 40) : ($urandom_range(99) < 5);
         wb_rd     = 5'(r);
         wb_cr     = (pend_cr_m > 0) && ($urandom_range(99) < 40);
         tick();
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      wb_valid = 1'b0;
      wb_cr    = 1'b0;
      retire_all();
      idle(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
